// File: rtl/reaction_timer_fsm_if.sv
// Key input and screen/score outputs of the reaction-timer game controller.
// Optional oBestMs signal exists only when BEST_SCORE_EN is defined.
interface reaction_timer_fsm_if;
  logic        iKey;
  logic [1:0]  oScreen;
  logic        oScreenChange;
  logic [13:0] oReactionMs;
  logic        oScoreValid;
  logic        oTooSoon;
`ifdef BEST_SCORE_EN
  logic [13:0] oBestMs;

  modport master (output iKey, input oScreen, oScreenChange, oReactionMs,
                  oScoreValid, oTooSoon, oBestMs);
  modport slave  (input iKey, output oScreen, oScreenChange, oReactionMs,
                  oScoreValid, oTooSoon, oBestMs);
`else
  modport master (output iKey, input oScreen, oScreenChange, oReactionMs,
                  oScoreValid, oTooSoon);
  modport slave  (input iKey, output oScreen, oScreenChange, oReactionMs,
                  oScoreValid, oTooSoon);
`endif
endinterface

// File: rtl/reaction_timer_fsm.sv
// Game-flow controller for the reaction test: MENU -> WAIT(red) -> GO(green) -> SCORE.
// Define BEST_SCORE_EN to add the best-time register on oBestMs.
module reaction_timer_fsm #(
  parameter int CLK_HZ          = 50000000,
  parameter int MIN_DELAY_MS    = 1000,
  parameter int DELAY_SPAN_LOG2 = 11,
  parameter int MAX_MS          = 9999
) (
  input logic                 clk,
  input logic                 iReset,
  reaction_timer_fsm_if.slave bus
);
  localparam int MS_DIV = CLK_HZ / 1000;
  localparam int DIV_W  = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(MS_DIV - 1);
  localparam logic [13:0] MAX_V = 14'(MAX_MS);
  localparam logic [13:0] MIN_V = 14'(MIN_DELAY_MS);

  typedef enum logic [1:0] {S_MENU = 2'd0, S_WAIT = 2'd1, S_GO = 2'd2, S_SCORE = 2'd3} state_e;

  state_e           state_q, state_d;
  logic             key_s1_q, key_s1_d, key_s2_q, key_s2_d, key_prev_q, key_prev_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [13:0]      ms_q, ms_d;
  logic [13:0]      delay_q, delay_d;
  logic [13:0]      react_q, react_d;
  logic             valid_q, valid_d, soon_q, soon_d;
  logic             chg_q, chg_d, started_q, started_d;
`ifdef BEST_SCORE_EN
  logic [13:0]      best_q, best_d;
`endif

  logic press, tick, expire, changed;

  assign press  = key_s2_q & ~key_prev_q;
  assign tick   = (div_q == DIV_LAST);
  assign expire = tick && (ms_q == delay_q - 14'd1);

  always_ff @(posedge clk or posedge iReset) begin
    if (iReset) begin
      state_q    <= S_MENU;
      key_s1_q   <= 1'b0;
      key_s2_q   <= 1'b0;
      key_prev_q <= 1'b0;
      lfsr_q     <= 16'hACE1;
      div_q      <= '0;
      ms_q       <= '0;
      delay_q    <= '0;
      react_q    <= '0;
      valid_q    <= 1'b0;
      soon_q     <= 1'b0;
      chg_q      <= 1'b0;
      started_q  <= 1'b0;
`ifdef BEST_SCORE_EN
      best_q     <= MAX_V;
`endif
    end else begin
      state_q    <= state_d;
      key_s1_q   <= key_s1_d;
      key_s2_q   <= key_s2_d;
      key_prev_q <= key_prev_d;
      lfsr_q     <= lfsr_d;
      div_q      <= div_d;
      ms_q       <= ms_d;
      delay_q    <= delay_d;
      react_q    <= react_d;
      valid_q    <= valid_d;
      soon_q     <= soon_d;
      chg_q      <= chg_d;
      started_q  <= started_d;
`ifdef BEST_SCORE_EN
      best_q     <= best_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    key_s1_d   = bus.iKey;
    key_s2_d   = key_s1_q;
    key_prev_d = key_s2_q;
    lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    delay_d    = delay_q;
    react_d    = react_q;
    valid_d    = valid_q;
    soon_d     = soon_q;
    started_d  = 1'b1;
`ifdef BEST_SCORE_EN
    best_d     = best_q;
`endif

    case (state_q)
      S_MENU: begin
        if (press) begin
          state_d = S_WAIT;
          delay_d = MIN_V + 14'(lfsr_q[DELAY_SPAN_LOG2-1:0]);
        end
      end
      S_WAIT: begin
        // an early press beats a delay expiry landing in the same cycle
        if (press) begin
          state_d = S_SCORE;
          soon_d  = 1'b1;
          valid_d = 1'b0;
          react_d = '0;
        end else if (expire) begin
          state_d = S_GO;
        end
      end
      S_GO: begin
        if (press) begin
          state_d = S_SCORE;
          react_d = ms_q;
          valid_d = 1'b1;
          soon_d  = 1'b0;
`ifdef BEST_SCORE_EN
          if (ms_q < best_q) best_d = ms_q;
`endif
        end else if (ms_q == MAX_V) begin
          state_d = S_SCORE;
          react_d = MAX_V;
          valid_d = 1'b1;
          soon_d  = 1'b0;
        end
      end
      S_SCORE: begin
        if (press) begin
          state_d = S_MENU;
          valid_d = 1'b0;
          soon_d  = 1'b0;
        end
      end
    endcase

    changed = (state_d != state_q);
    // the timebase restarts on every screen so WAIT/GO measure from entry
    if (changed) begin
      div_d = '0;
      ms_d  = '0;
    end else begin
      div_d = tick ? '0 : div_q + 1'b1;
      ms_d  = (tick && ms_q != MAX_V) ? ms_q + 14'd1 : ms_q;
    end
    chg_d = changed | ~started_q;
  end

  assign bus.oScreen       = state_q;
  assign bus.oScreenChange = chg_q;
  assign bus.oReactionMs   = react_q;
  assign bus.oScoreValid   = valid_q;
  assign bus.oTooSoon      = soon_q;
`ifdef BEST_SCORE_EN
  assign bus.oBestMs       = best_q;
`endif
endmodule

// File: tb/tb_reaction_timer_fsm.sv
// Self-checking bench: table of game runs, scoreboard of expected redraws, plus
// hand-written reset and timeout sequences (timeout on a fast-timebase second instance).
`timescale 1ns/1ps
module tb_reaction_timer_fsm;
  localparam int MAXMS = 9999;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reaction_timer_fsm_if if1();
  reaction_timer_fsm_if if2();

  reaction_timer_fsm #(.CLK_HZ(10000), .MIN_DELAY_MS(5), .DELAY_SPAN_LOG2(2), .MAX_MS(MAXMS))
    dut (.clk(clk), .iReset(rst), .bus(if1));
  reaction_timer_fsm #(.CLK_HZ(2000), .MIN_DELAY_MS(5), .DELAY_SPAN_LOG2(2), .MAX_MS(MAXMS))
    dut2 (.clk(clk), .iReset(rst), .bus(if2));

  typedef struct { int scr; int ms; int vld; int soon; int best; } exp_t;
  typedef struct { bit soon; int offs; int hold; int exp_ms; } run_t;

  exp_t sbq[$];
  int   checks, errors;
  int   best_m, last_ms;
  exp_t mon_e;
  bit   mon_bad;

  // reference LFSR; lfsr_used is the value that was current in the previous cycle
  logic [15:0] m, lfsr_used;
  always @(posedge clk or posedge rst)
    if (rst) begin m <= 16'hACE1; lfsr_used <= 16'hACE1; end
    else begin lfsr_used <= m; m <= {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]}; end

  function automatic exp_t mk(int s, int ms, int v, int so, int b);
    exp_t e;
    e.scr = s; e.ms = ms; e.vld = v; e.soon = so; e.best = b;
    return e;
  endfunction

  function automatic int best_out(int w);
`ifdef BEST_SCORE_EN
    return (w == 1) ? int'(if1.oBestMs) : int'(if2.oBestMs);
`else
    return (w == 1) ? best_m : MAXMS;
`endif
  endfunction

  function automatic int scr(int w);
    return (w == 1) ? int'(if1.oScreen) : int'(if2.oScreen);
  endfunction

  // every redraw pulse must match the next expected screen/score record
  always @(negedge clk) begin
    if (!rst && if1.oScreenChange === 1'b1) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL redraw: unexpected pulse, screen=%0d", if1.oScreen);
      end else begin
        mon_e   = sbq.pop_front();
        mon_bad = (int'(if1.oScreen) != mon_e.scr) || (int'(if1.oReactionMs) != mon_e.ms) ||
                  (int'(if1.oScoreValid) != mon_e.vld) || (int'(if1.oTooSoon) != mon_e.soon);
`ifdef BEST_SCORE_EN
        mon_bad = mon_bad || (int'(if1.oBestMs) != mon_e.best);
`endif
        if (mon_bad) begin
          errors++;
          $display("FAIL redraw: got scr=%0d ms=%0d vld=%0d soon=%0d best=%0d, expected scr=%0d ms=%0d vld=%0d soon=%0d best=%0d",
                   if1.oScreen, if1.oReactionMs, if1.oScoreValid, if1.oTooSoon, best_out(1),
                   mon_e.scr, mon_e.ms, mon_e.vld, mon_e.soon, mon_e.best);
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic key(input int w, input logic v);
    if (w == 1) if1.iKey = v; else if2.iKey = v;
  endtask

  task automatic press_hold(input int w, input int hold);
    key(w, 1'b1);
    repeat (hold) @(negedge clk);
    key(w, 1'b0);
  endtask

  task automatic wait_scr(input int w, input int s, input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (scr(w) != s && n < budget);
    checks++;
    if (scr(w) != s) begin
      errors++;
      $display("FAIL wait_screen%0d: got %0d expected %0d within %0d cycles", w, scr(w), s, budget);
    end
  endtask

  task automatic do_run(input run_t r);
    int d, n;
    sbq.push_back(mk(1, last_ms, 0, 0, best_m));
    key(1, 1'b1);
    repeat (2) @(negedge clk);
    chk("menu_before_3rd_edge", scr(1), 0);
    @(negedge clk);
    chk("wait_on_3rd_edge", scr(1), 1);
    d = 5 + int'(lfsr_used[1:0]);
    if (r.soon) begin
      for (int i = 1; i <= r.offs; i++) begin
        @(negedge clk);
        if (i == r.hold) key(1, 1'b0);
      end
      sbq.push_back(mk(3, 0, 0, 1, best_m));
      last_ms = 0;
      press_hold(1, 4);
      wait_scr(1, 3, 20, n);
    end else begin
      sbq.push_back(mk(2, last_ms, 0, 0, best_m));
      for (int i = 1; i <= d * 10; i++) begin
        @(negedge clk);
        if (i == r.hold) key(1, 1'b0);
        if (i == d * 10 - 1) chk("wait_before_delay", scr(1), 1);
      end
      chk("go_at_delay", scr(1), 2);
      key(1, 1'b0);
      if (r.exp_ms < best_m) best_m = r.exp_ms;
      last_ms = r.exp_ms;
      sbq.push_back(mk(3, r.exp_ms, 1, 0, best_m));
      repeat (r.offs) @(negedge clk);
      press_hold(1, 4);
      wait_scr(1, 3, 20, n);
    end
    sbq.push_back(mk(0, last_ms, 0, 0, best_m));
    press_hold(1, 4);
    wait_scr(1, 0, 20, n);
    repeat (3) @(negedge clk);
  endtask

  run_t runs[4];

  initial begin
    int n;
    runs[0] = '{soon: 1'b1, offs: 20,  hold: 3,  exp_ms: 0};
    runs[1] = '{soon: 1'b0, offs: 371, hold: 4,  exp_ms: 37};
    runs[2] = '{soon: 1'b0, offs: 501, hold: 4,  exp_ms: 50};
    runs[3] = '{soon: 1'b0, offs: 121, hold: 60, exp_ms: 12};
    checks = 0; errors = 0; best_m = MAXMS; last_ms = 0;
    if1.iKey = 1'b0; if2.iKey = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #11;
    chk("rst_screen", scr(1), 0);
    chk("rst_change", int'(if1.oScreenChange), 0);
    chk("rst_ms", int'(if1.oReactionMs), 0);
    chk("rst_valid", int'(if1.oScoreValid), 0);
    chk("rst_toosoon", int'(if1.oTooSoon), 0);
    chk("rst_best", best_out(1), MAXMS);
    sbq.push_back(mk(0, 0, 0, 0, MAXMS));
    @(negedge clk) rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("menu_redraw_seen", sbq.size(), 0);

    foreach (runs[i]) do_run(runs[i]);

    // asynchronous reset in the middle of GO, with a press only while reset is held
    sbq.push_back(mk(1, last_ms, 0, 0, best_m));
    press_hold(1, 4);
    wait_scr(1, 1, 10, n);
    sbq.push_back(mk(2, last_ms, 0, 0, best_m));
    wait_scr(1, 2, 200, n);
    repeat (100) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_screen", scr(1), 0);
    chk("arst_change", int'(if1.oScreenChange), 0);
    chk("arst_ms", int'(if1.oReactionMs), 0);
    chk("arst_valid", int'(if1.oScoreValid), 0);
    best_m = MAXMS; last_ms = 0;
    chk("arst_best", best_out(1), MAXMS);
    @(negedge clk);
    press_hold(1, 3);
    repeat (3) @(negedge clk);
    sbq.push_back(mk(0, 0, 0, 0, MAXMS));
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("press_in_reset_ignored", scr(1), 0);
    chk("post_reset_redraw", sbq.size(), 0);

    // timeout on the fast-timebase instance: 2 cycles per ms
    press_hold(2, 4);
    wait_scr(2, 2, 100, n);
    repeat (21) @(negedge clk);
    press_hold(2, 4);
    wait_scr(2, 3, 20, n);
    chk("d2_press_ms", int'(if2.oReactionMs), 11);
    chk("d2_press_valid", int'(if2.oScoreValid), 1);
`ifdef BEST_SCORE_EN
    chk("d2_best_after_press", int'(if2.oBestMs), 11);
`endif
    press_hold(2, 4);
    wait_scr(2, 0, 20, n);
    repeat (3) @(negedge clk);
    press_hold(2, 4);
    wait_scr(2, 2, 100, n);
    wait_scr(2, 3, 25000, n);
    chk("timeout_cycles", n, 19999);
    chk("timeout_ms", int'(if2.oReactionMs), MAXMS);
    chk("timeout_valid", int'(if2.oScoreValid), 1);
    chk("timeout_toosoon", int'(if2.oTooSoon), 0);
`ifdef BEST_SCORE_EN
    chk("timeout_best_kept", int'(if2.oBestMs), 11);
`endif

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
